// File: rtl/way_age_tracker_pkg.sv
// way_age_tracker_pkg: shared query FSM state encoding for the way age tracker
package way_age_tracker_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    RESP = 2'd2
  } state_t;
endpackage

// File: rtl/way_age_counter.sv
// way_age_counter: one way's age, cleared on access, saturating increment otherwise
module way_age_counter #(
  parameter int W = 4
) (
  input  logic         clk_in,
  input  logic         reset_in,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] age
);
  always_ff @(posedge clk_in or posedge reset_in)
    if (reset_in) age <= '0;
    else age <= clr ? '0 : (inc && age != '1) ? age + 1'b1 : age;
endmodule

// File: rtl/way_age_tracker.sv
// way_age_tracker: per-way LRU ages plus a serial max-age victim scan.
// Define WAY_AGE_TRACKER_INVALID_FIRST_EN to stop the scan at the first empty way.
module way_age_tracker
  import way_age_tracker_pkg::*;
#(
  parameter int SINGLE_WAY_WIDTH_IN_BITS = 4,
  parameter int NUM_WAY = 16,
  parameter int WAY_PTR_WIDTH_IN_BITS = $clog2(NUM_WAY) + 1
) (
  input  logic                                       clk_in,
  input  logic                                       reset_in,
  input  logic                                       access_valid_in,
  input  logic [WAY_PTR_WIDTH_IN_BITS-1:0]           access_way_in,
  input  logic [NUM_WAY-1:0]                         valid_mask_in,
  input  logic                                       victim_req_valid_in,
  output logic                                       victim_req_ready_out,
  output logic                                       victim_valid_out,
  input  logic                                       victim_ready_in,
  output logic [WAY_PTR_WIDTH_IN_BITS-1:0]           victim_way_out,
  output logic [SINGLE_WAY_WIDTH_IN_BITS-1:0]        victim_age_out,
  output logic [SINGLE_WAY_WIDTH_IN_BITS*NUM_WAY-1:0] way_age_flatted_out
);
  localparam int W = SINGLE_WAY_WIDTH_IN_BITS;
  localparam int WP = WAY_PTR_WIDTH_IN_BITS;
  localparam int IW = NUM_WAY > 1 ? $clog2(NUM_WAY) : 1;
  logic [NUM_WAY-1:0][W-1:0] ages;
  logic acc_ok;
  state_t state;
  logic [WP-1:0] scan_idx, best_way;
  logic [W-1:0] best_age, cur_age;
  logic done;
  assign acc_ok = access_valid_in && access_way_in < WP'(NUM_WAY);
  for (genvar i = 0; i < NUM_WAY; i++) begin : g_way
    way_age_counter #(.W(W)) u_cnt (
      .clk_in  (clk_in),
      .reset_in(reset_in),
      .clr     (acc_ok && access_way_in == WP'(i)),
      .inc     (acc_ok && valid_mask_in[i] && access_way_in != WP'(i)),
      .age     (ages[i])
    );
  end
  assign way_age_flatted_out = ages;
  assign cur_age = valid_mask_in[scan_idx[IW-1:0]] ? ages[scan_idx[IW-1:0]] : '0;
  assign victim_req_ready_out = state == IDLE;
  assign victim_valid_out = state == RESP;
  assign victim_way_out = best_way;
  assign victim_age_out = best_age;
  // done delays the RESP entry by one edge after the deciding way is examined
  always_ff @(posedge clk_in or posedge reset_in)
    if (reset_in) begin
      state <= IDLE;
      scan_idx <= '0;
      best_way <= '0;
      best_age <= '0;
      done <= 1'b0;
    end else begin
      case (state)
        IDLE: if (victim_req_valid_in) begin
          state <= SCAN;
          scan_idx <= '0;
          best_way <= '0;
          best_age <= '0;
          done <= 1'b0;
        end
        SCAN: if (done) state <= RESP;
        else begin
          if (cur_age > best_age) begin
            best_way <= scan_idx;
            best_age <= cur_age;
          end
`ifdef WAY_AGE_TRACKER_INVALID_FIRST_EN
          if (!valid_mask_in[scan_idx[IW-1:0]]) begin
            best_way <= scan_idx;
            best_age <= '0;
            done <= 1'b1;
          end else
`endif
          if (scan_idx == WP'(NUM_WAY - 1)) done <= 1'b1;
          else scan_idx <= scan_idx + 1'b1;
        end
        RESP: if (victim_ready_in) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_way_age_tracker.sv
// tb_way_age_tracker: random + directed checks of way_age_tracker against a behavioural model
module tb_way_age_tracker;
  localparam int N = 4;
  localparam int W = 4;
  localparam int WP = 3;
  logic clk_in = 1'b0;
  logic reset_in = 1'b1;
  logic access_valid_in = 1'b0;
  logic [WP-1:0] access_way_in = '0;
  logic [N-1:0] valid_mask_in = '1;
  logic victim_req_valid_in = 1'b0;
  logic victim_req_ready_out;
  logic victim_valid_out;
  logic victim_ready_in = 1'b0;
  logic [WP-1:0] victim_way_out;
  logic [W-1:0] victim_age_out;
  logic [W*N-1:0] way_age_flatted_out;
  int checks = 0;
  int errors = 0;

  way_age_tracker #(.SINGLE_WAY_WIDTH_IN_BITS(W), .NUM_WAY(N), .WAY_PTR_WIDTH_IN_BITS(WP)) dut (
    .clk_in(clk_in), .reset_in(reset_in), .access_valid_in(access_valid_in),
    .access_way_in(access_way_in), .valid_mask_in(valid_mask_in),
    .victim_req_valid_in(victim_req_valid_in), .victim_req_ready_out(victim_req_ready_out),
    .victim_valid_out(victim_valid_out), .victim_ready_in(victim_ready_in),
    .victim_way_out(victim_way_out), .victim_age_out(victim_age_out),
    .way_age_flatted_out(way_age_flatted_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: ages as integers; a query remembers how many edges have passed since acceptance,
  // and the way judged at edge k is way k-1 using its age just before that edge.
  int m_age[N];
  bit m_idle, m_resp;
  int m_cnt, m_stop, m_bw, m_ba;
  always @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      foreach (m_age[i]) m_age[i] = 0;
      m_idle = 1; m_resp = 0; m_cnt = 0; m_stop = 0; m_bw = 0; m_ba = 0;
    end else begin
      if (m_idle) begin
        if (victim_req_valid_in) begin
          m_idle = 0; m_cnt = 0; m_stop = N + 1; m_bw = 0; m_ba = 0;
        end
      end else if (!m_resp) begin
        m_cnt++;
        if (m_cnt == m_stop) m_resp = 1;
        else begin
          int k, a;
          k = m_cnt - 1;
          a = valid_mask_in[k] ? m_age[k] : 0;
          if (a > m_ba) begin m_bw = k; m_ba = a; end
`ifdef WAY_AGE_TRACKER_INVALID_FIRST_EN
          if (!valid_mask_in[k]) begin m_bw = k; m_ba = 0; m_stop = m_cnt + 1; end
`endif
        end
      end else if (victim_ready_in) begin
        m_idle = 1; m_resp = 0;
      end
      if (access_valid_in && access_way_in < N)
        for (int i = 0; i < N; i++)
          if (i == access_way_in) m_age[i] = 0;
          else if (valid_mask_in[i] && m_age[i] < (1 << W) - 1) m_age[i]++;
    end
  end

  always @(negedge clk_in) begin
    chk("ready", victim_req_ready_out, m_idle);
    chk("valid", victim_valid_out, m_resp);
    if (m_resp) begin
      chk("way", victim_way_out, m_bw);
      chk("age", victim_age_out, m_ba);
    end
    if (reset_in) begin
      chk("rst_way", victim_way_out, 0);
      chk("rst_age", victim_age_out, 0);
    end
    for (int i = 0; i < N; i++) chk($sformatf("age%0d", i), way_age_flatted_out[i*W +: W], m_age[i]);
  end

  task automatic do_reset();
    reset_in = 1'b1;
    @(posedge clk_in); #1;
    reset_in = 1'b0;
  endtask

  task automatic acc(input int w, input logic [N-1:0] m);
    access_valid_in = 1'b1; access_way_in = WP'(w); valid_mask_in = m;
    @(posedge clk_in); #1;
    access_valid_in = 1'b0;
  endtask

  task automatic query(input int lat, input int way, input int age, input int hold);
    int n;
    victim_req_valid_in = 1'b1;
    @(posedge clk_in); #1;
    victim_req_valid_in = 1'b0;
    for (n = 1; n <= 40; n++) begin
      @(posedge clk_in); #1;
      if (victim_valid_out) break;
    end
    chk("latency", n, lat);
    if (n > 40) return;
    chk("q_way", victim_way_out, way);
    chk("q_age", victim_age_out, age);
    repeat (hold) begin
      @(posedge clk_in); #1;
      chk("hold_ready", victim_req_ready_out, 0);
      chk("hold_way", victim_way_out, way);
    end
    victim_ready_in = 1'b1;
    @(posedge clk_in); #1;
    victim_ready_in = 1'b0;
    chk("ready_after", victim_req_ready_out, 1);
  endtask

  initial begin
    repeat (2) @(posedge clk_in);
    #1 reset_in = 1'b0;
    chk("rst_flat", way_age_flatted_out, 0);
    chk("rst_ready", victim_req_ready_out, 1);
    for (int i = 0; i < N; i++) acc(i, 4'b1111);
    chk("seq_flat", way_age_flatted_out, 16'h0123);
    query(5, 0, 3, 0);
    repeat (20) acc(1, 4'b1111);
    chk("sat_flat", way_age_flatted_out, 16'hFF0F);
    query(5, 0, 15, 10);
    do_reset();
    acc(3, 4'b0101);
    chk("mask_flat", way_age_flatted_out, 16'h0101);
    acc(5, 4'b1111);
    chk("oob_flat", way_age_flatted_out, 16'h0101);
    acc(0, 4'b1111);
    victim_req_valid_in = 1'b1;
    @(posedge clk_in); #1;
    victim_req_valid_in = 1'b0;
    repeat (2) @(posedge clk_in);
    #1 do_reset();
    chk("abort_flat", way_age_flatted_out, 0);
    repeat (10) begin
      @(posedge clk_in); #1;
      chk("abort_valid", victim_valid_out, 0);
    end
    valid_mask_in = 4'b1011;
`ifdef WAY_AGE_TRACKER_INVALID_FIRST_EN
    query(4, 2, 0, 0);
`else
    query(5, 0, 0, 0);
`endif
    for (int c = 0; c < 3000; c++) begin
      access_valid_in = 1'($urandom_range(0, 1));
      access_way_in = WP'($urandom_range(0, 7));
      valid_mask_in = ($urandom_range(0, 3) == 0) ? N'($urandom) : '1;
      victim_req_valid_in = ($urandom_range(0, 3) == 0);
      victim_ready_in = 1'($urandom_range(0, 1));
      reset_in = ($urandom_range(0, 199) == 0);
      @(posedge clk_in); #1;
    end
    reset_in = 1'b0;
    access_valid_in = 1'b0;
    victim_req_valid_in = 1'b0;
    @(posedge clk_in); #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/way_age_tracker.md
WAY_AGE_TRACKER -- requirements
Module: way_age_tracker

Interface
REQ-001 Parameter SINGLE_WAY_WIDTH_IN_BITS, default 4, SHALL set the width of one way's age counter.
REQ-002 Parameter NUM_WAY, default 16, SHALL set the number of tracked ways; legal values are 1, 2, 4, 8, 16.
REQ-003 Parameter WAY_PTR_WIDTH_IN_BITS, default $clog2(NUM_WAY)+1, SHALL set the width of every way pointer.
REQ-004 clk_in  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 reset_in  input  1  SHALL be the asynchronous, active-high reset.
REQ-006 access_valid_in  input  1  SHALL mark an access to access_way_in in the current cycle.
REQ-007 access_way_in  input  WAY_PTR_WIDTH_IN_BITS  SHALL be the way index of the access.
REQ-008 valid_mask_in  input  NUM_WAY  SHALL give per-way occupancy; bit i high means way i holds data.
REQ-009 victim_req_valid_in / victim_req_ready_out  input / output  1 each  SHALL form the victim-query request handshake.
REQ-010 victim_valid_out / victim_ready_in  output / input  1 each  SHALL form the victim-response handshake.
REQ-011 victim_way_out  output  WAY_PTR_WIDTH_IN_BITS  SHALL carry the selected victim way.
REQ-012 victim_age_out  output  SINGLE_WAY_WIDTH_IN_BITS  SHALL carry the age of the selected victim.
REQ-013 way_age_flatted_out  output  SINGLE_WAY_WIDTH_IN_BITS*NUM_WAY  SHALL expose all ages, way i at bits [i*W +: W], registered and directly consumable by the team's combinational max-selector.

Function
REQ-014 Edges with access_valid_in=1 and access_way_in<NUM_WAY SHALL clear the accessed way's age to 0 and increment every other way whose valid_mask_in bit is 1, saturating at all-ones.
REQ-015 Ways whose valid_mask_in bit is 0 SHALL hold their age on an access.
REQ-016 Accesses with access_way_in>=NUM_WAY SHALL be ignored entirely, and no age SHALL change while access_valid_in=0.
REQ-017 The query FSM SHALL have states IDLE, SCAN and RESP, and victim_req_ready_out SHALL equal 1 exactly in IDLE.
REQ-018 IDLE->SCAN SHALL occur on an edge with victim_req_valid_in=1 in IDLE, initialising best_way=0, best_age=0, scan_idx=0.
REQ-019 SCAN SHALL examine way scan_idx once per cycle, treating an age as 0 when its valid_mask_in bit is 0, and replace the best candidate only on strictly greater age, so ties resolve to the lowest index.
REQ-020 SCAN SHALL read live ages, so accesses during the scan are visible to ways not yet examined.
REQ-021 SCAN->RESP SHALL occur after way NUM_WAY-1 is examined, giving victim_valid_out=1 exactly NUM_WAY+1 edges after the accepting edge.
REQ-022 In RESP, victim_way_out and victim_age_out SHALL be stable while victim_valid_out=1, and RESP->IDLE SHALL occur on the edge with victim_ready_in=1.
REQ-023 When no way is valid, the response SHALL be victim_way_out=0, victim_age_out=0.
REQ-024 victim_valid_out SHALL be 0 outside RESP.

Reset
REQ-025 reset_in=1 SHALL immediately force all ages to 0, the FSM to IDLE, victim_way_out=0, victim_age_out=0, victim_valid_out=0 and victim_req_ready_out=1, regardless of any scan or response in progress.
REQ-026 A request aborted by reset SHALL produce no response.

Configuration
REQ-027 With WAY_AGE_TRACKER_INVALID_FIRST_EN defined, SCAN SHALL exit to RESP on the first examined way with valid_mask_in bit 0 and return that way with age 0, giving a latency of scan_idx+2 edges.
REQ-028 Without WAY_AGE_TRACKER_INVALID_FIRST_EN, every scan SHALL take the full NUM_WAY cycles as in REQ-021.

Structure
REQ-029 The FSM state encoding (IDLE=2'd0, SCAN=2'd1, RESP=2'd2) SHALL reside in the shared package.
REQ-030 Per-way clear/increment/saturate SHALL be a sub-module way_age_counter, instantiated NUM_WAY times.

Verification (NUM_WAY=4, W=4, unless stated otherwise)
REQ-031 Reset, then accesses to ways 0, 1, 2, 3 with mask 4'b1111 -> ages {w0..w3} = {3,2,1,0}; a query returns way 0, age 3, valid at edge 5 after accept.
REQ-032 Twenty consecutive accesses to way 1 with mask 4'b1111 -> ways 0, 2 and 3 saturate at 15 and way 1 is 0; a query returns way 0 (tie, lowest index).
REQ-033 Mask 4'b0101 and an access to way 3 -> only way 0 and way 2 increment; access_way_in=5 -> no change.
REQ-034 victim_ready_in held at 0 for 10 cycles in RESP -> outputs stable and victim_req_ready_out=0; the cycle after ready=1, victim_req_ready_out=1.
REQ-035 reset_in pulsed mid-SCAN -> outputs at reset values, no victim_valid_out, all ages 0.
REQ-036 WAY_AGE_TRACKER_INVALID_FIRST_EN defined with mask 4'b1011 -> way 2, age 0, valid 4 edges after accept.
